memory_port_arbiter: RTL
========================

// Module: memory_port_arbiter
// PURPOSE
//  Shares one unified main-memory port between the core's fetch (i-side) and load/store (d-side)
//  requesters. Arbitrates, holds one outstanding transaction, routes read responses to the owner.
//  Sits between the single-cycle core's fetch/memory interfaces and the shared memory port.
//  Busy time appears to the core as i_mem/d_mem hazards via the requester-side ready/valid signals.
// PARAMETERS
//  CORE            0     core index, used in scan output only
//  DATA_WIDTH      32    memory word width
//  ADDRESS_BITS    20    address width
//  ROUND_ROBIN     0     0 = d-side fixed priority; 1 = alternate when both request
//  STARVE_LIMIT    4     consecutive d grants before i is forced (ARB_STARVE_GUARD_EN only)
//  SCAN_CYCLES_MIN 0     first cycle of scan display window
//  SCAN_CYCLES_MAX 1000  last cycle of scan display window
// PORTS
//  clock            in   1             single clock, rising edge
//  reset            in   1             asynchronous, active-high
//  i_req_valid      in   1             fetch read request
//  i_req_address    in   ADDRESS_BITS  fetch address
//  i_req_ready      out  1             fetch request accepted this cycle
//  i_resp_valid     out  1             fetch data valid (1-cycle pulse)
//  i_resp_data      out  DATA_WIDTH    fetch data
//  i_resp_address   out  ADDRESS_BITS  address of returned fetch data
//  d_req_read       in   1             load request
//  d_req_write      in   1             store request
//  d_req_address    in   ADDRESS_BITS  load/store address
//  d_req_data       in   DATA_WIDTH    store data
//  d_req_ready      out  1             d request accepted this cycle
//  d_resp_valid     out  1             load data valid (1-cycle pulse)
//  d_resp_data      out  DATA_WIDTH    load data
//  d_resp_address   out  ADDRESS_BITS  address of returned load data
//  mem_read         out  1             read command to memory
//  mem_write        out  1             write command to memory
//  mem_address      out  ADDRESS_BITS  command address
//  mem_data_out     out  DATA_WIDTH    write data
//  mem_ready        in   1             memory accepts command this cycle
//  mem_resp_valid   in   1             memory read data valid
//  mem_resp_data    in   DATA_WIDTH    memory read data
//  mem_resp_address in   ADDRESS_BITS  address tag of read data
//  scan             in   1             enables $display trace within the scan window
// BEHAVIOUR
//  Reset: state=IDLE; every output, owner, op and address/data registers, rr pointer and starve counter 0.
//   Reset mid-transaction drops the transaction. Responses arriving in IDLE/ISSUE are discarded.
//  FSM IDLE -> ISSUE -> (WAIT_RESP) -> IDLE; exactly one outstanding transaction.
//   IDLE: on any request, select owner. *_req_ready is combinational: high in IDLE for the selected side only.
//     Latch op, address and data; go to ISSUE.
//     d_req_read & d_req_write together: write is taken, read is ignored.
//   ISSUE: mem_read/mem_write/mem_address/mem_data_out are driven from the latched registers and held until mem_ready.
//     On mem_ready: write -> IDLE, with no response; read -> WAIT_RESP.
//   WAIT_RESP: on mem_resp_valid & mem_resp_address==latched address, register data/address into the owner's resp
//     and pulse owner *_resp_valid the next cycle; -> IDLE. A tag mismatch is ignored and the FSM keeps waiting.
//  Min read latency: accept c0, issue c1 (mem_ready=1), resp in c2, *_resp_valid c3. Store: accept c0, done c1.
//  Arbitration: ROUND_ROBIN=0 -> d wins ties. ROUND_ROBIN=1 -> the side not granted last wins ties.
//   The rr pointer updates only on a grant.
//  Back-to-back: a new grant is possible the cycle after returning to IDLE; no grant is made in the resp-pulse cycle.
// CONFIGURATION
//  ARB_STARVE_GUARD_EN defined: counter of consecutive d grants made while i_req_valid was high.
//   When it reaches STARVE_LIMIT, the next tie goes to i. Counter clears on any i grant or when i is idle.
//  Undefined: no counter; arbitration is exactly per ROUND_ROBIN.
// STRUCTURE
//  Shared include mem_arbiter_defs.vh: state encodings IDLE/ISSUE/WAIT_RESP, OWNER_I/OWNER_D, OP_READ/OP_WRITE localparams.
//  One sub-module arb2_select: 2-way fixed/round-robin chooser with pointer register.
//  Same async reset as this block.
// TESTING
//  1 i read 0x00040, mem_ready=1, resp one cycle later -> i_req_ready c0, mem_read c1, i_resp_valid c3 data match.
//  2 i read & d read same cycle, ROUND_ROBIN=0 -> d granted first; i granted the cycle after d's resp pulse.
//  3 d write 0x00100/0xDEADBEEF, mem_ready low 3 cycles -> mem_write held 4 cycles, no d_resp_valid.
//  4 ROUND_ROBIN=1, both requesting continuously for 6 grants -> grants alternate d,i,d,i,d,i.
//  5 reset asserted in WAIT_RESP, then a late mem_resp_valid -> no resp pulse; all outputs 0; FSM in IDLE.
//  6 ARB_STARVE_GUARD_EN, STARVE_LIMIT=4, d and i requesting continuously -> 4 d grants then 1 i grant, repeating.

Source files
------------

// File: rtl/memory_port_arbiter_pkg.sv
// Shared types for memory_port_arbiter: FSM states, transaction owner and memory operation.
package memory_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_RESP
    } state_e;

    typedef enum logic {
        OWNER_I,
        OWNER_D
    } owner_e;

    typedef enum logic {
        OP_READ,
        OP_WRITE
    } op_e;

endpackage

// File: rtl/memory_port_arbiter_arb2_select.sv
// Two-way requester chooser: d-side fixed priority, or alternate on ties when ROUND_ROBIN != 0.
module memory_port_arbiter_arb2_select
    import memory_port_arbiter_pkg::*;
#(
    parameter int unsigned ROUND_ROBIN = 0
) (
    input  logic   clock,
    input  logic   reset,
    input  logic   req_i,
    input  logic   req_d,
    input  logic   force_i,
    input  logic   grant,
    output owner_e owner
);

    owner_e last_q;
    owner_e last_d;

    always_comb begin
        owner = OWNER_D;
        if (req_i && !req_d) begin
            owner = OWNER_I;
        end else if (req_i && req_d) begin
            if (force_i) begin
                owner = OWNER_I;
            end else if ((ROUND_ROBIN != 0) && (last_q == OWNER_D)) begin
                owner = OWNER_I;
            end
        end
    end

    // Pointer remembers the side granted last; it moves only when a grant is made.
    always_comb begin
        last_d = last_q;
        if (grant) begin
            last_d = owner;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            last_q <= OWNER_I;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/memory_port_arbiter.sv
// Shares one memory port between fetch (i) and load/store (d) with one outstanding transaction.
// Optional ARB_STARVE_GUARD_EN forces an i grant after STARVE_LIMIT consecutive contested d grants.
module memory_port_arbiter
    import memory_port_arbiter_pkg::*;
#(
    parameter int unsigned CORE            = 0,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned ADDRESS_BITS    = 20,
    parameter int unsigned ROUND_ROBIN     = 0,
    parameter int unsigned STARVE_LIMIT    = 4,
    parameter int unsigned SCAN_CYCLES_MIN = 0,
    parameter int unsigned SCAN_CYCLES_MAX = 1000
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    i_req_valid,
    input  logic [ADDRESS_BITS-1:0] i_req_address,
    output logic                    i_req_ready,
    output logic                    i_resp_valid,
    output logic [DATA_WIDTH-1:0]   i_resp_data,
    output logic [ADDRESS_BITS-1:0] i_resp_address,
    input  logic                    d_req_read,
    input  logic                    d_req_write,
    input  logic [ADDRESS_BITS-1:0] d_req_address,
    input  logic [DATA_WIDTH-1:0]   d_req_data,
    output logic                    d_req_ready,
    output logic                    d_resp_valid,
    output logic [DATA_WIDTH-1:0]   d_resp_data,
    output logic [ADDRESS_BITS-1:0] d_resp_address,
    output logic                    mem_read,
    output logic                    mem_write,
    output logic [ADDRESS_BITS-1:0] mem_address,
    output logic [DATA_WIDTH-1:0]   mem_data_out,
    input  logic                    mem_ready,
    input  logic                    mem_resp_valid,
    input  logic [DATA_WIDTH-1:0]   mem_resp_data,
    input  logic [ADDRESS_BITS-1:0] mem_resp_address,
    input  logic                    scan
);

    state_e                  state_q, state_d;
    owner_e                  owner_q, owner_d;
    op_e                     op_q, op_d;
    logic [ADDRESS_BITS-1:0] addr_q, addr_d;
    logic                    mem_read_q, mem_read_d;
    logic                    mem_write_q, mem_write_d;
    logic [ADDRESS_BITS-1:0] mem_address_q, mem_address_d;
    logic [DATA_WIDTH-1:0]   mem_data_out_q, mem_data_out_d;
    logic                    i_resp_valid_q, i_resp_valid_d;
    logic [DATA_WIDTH-1:0]   i_resp_data_q, i_resp_data_d;
    logic [ADDRESS_BITS-1:0] i_resp_address_q, i_resp_address_d;
    logic                    d_resp_valid_q, d_resp_valid_d;
    logic [DATA_WIDTH-1:0]   d_resp_data_q, d_resp_data_d;
    logic [ADDRESS_BITS-1:0] d_resp_address_q, d_resp_address_d;

    logic   d_req;
    logic   grant;
    logic   force_i;
    logic   take_write;
    owner_e sel;
    logic   unused_cfg;

    // Scan tracing is simulation-only; the configuration is kept for interface compatibility.
    assign unused_cfg = scan ^ (CORE > 0) ^ (SCAN_CYCLES_MIN > SCAN_CYCLES_MAX) ^ (STARVE_LIMIT > 0);

    assign d_req      = d_req_read | d_req_write;
    // No grant while a response pulse is on the outputs, so back-to-back grants are one cycle apart.
    assign grant      = !reset && (state_q == ST_IDLE) && !i_resp_valid_q && !d_resp_valid_q
                        && (i_req_valid || d_req);
    assign take_write = (sel == OWNER_D) && d_req_write;

    assign i_req_ready = grant && (sel == OWNER_I);
    assign d_req_ready = grant && (sel == OWNER_D);

    memory_port_arbiter_arb2_select #(
        .ROUND_ROBIN(ROUND_ROBIN)
    ) u_arb2_select (
        .clock  (clock),
        .reset  (reset),
        .req_i  (i_req_valid),
        .req_d  (d_req),
        .force_i(force_i),
        .grant  (grant),
        .owner  (sel)
    );

`ifdef ARB_STARVE_GUARD_EN
    localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);
    logic [STARVE_W-1:0] starve_q, starve_d;

    assign force_i = (starve_q == STARVE_W'(STARVE_LIMIT));

    always_comb begin
        starve_d = starve_q;
        if (!i_req_valid || (grant && (sel == OWNER_I))) begin
            starve_d = '0;
        end else if (grant && !force_i) begin
            starve_d = starve_q + 1'b1;
        end
    end
`else
    assign force_i = 1'b0;
`endif

    always_comb begin
        state_d          = state_q;
        owner_d          = owner_q;
        op_d             = op_q;
        addr_d           = addr_q;
        mem_read_d       = mem_read_q;
        mem_write_d      = mem_write_q;
        mem_address_d    = mem_address_q;
        mem_data_out_d   = mem_data_out_q;
        i_resp_valid_d   = 1'b0;
        i_resp_data_d    = i_resp_data_q;
        i_resp_address_d = i_resp_address_q;
        d_resp_valid_d   = 1'b0;
        d_resp_data_d    = d_resp_data_q;
        d_resp_address_d = d_resp_address_q;
        case (state_q)
            ST_IDLE: begin
                if (grant) begin
                    owner_d        = sel;
                    op_d           = take_write ? OP_WRITE : OP_READ;
                    addr_d         = (sel == OWNER_D) ? d_req_address : i_req_address;
                    mem_read_d     = !take_write;
                    mem_write_d    = take_write;
                    mem_address_d  = addr_d;
                    mem_data_out_d = take_write ? d_req_data : '0;
                    state_d        = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (mem_ready) begin
                    mem_read_d     = 1'b0;
                    mem_write_d    = 1'b0;
                    mem_address_d  = '0;
                    mem_data_out_d = '0;
                    state_d        = (op_q == OP_WRITE) ? ST_IDLE : ST_WAIT_RESP;
                end
            end
            ST_WAIT_RESP: begin
                if (mem_resp_valid && (mem_resp_address == addr_q)) begin
                    if (owner_q == OWNER_I) begin
                        i_resp_valid_d   = 1'b1;
                        i_resp_data_d    = mem_resp_data;
                        i_resp_address_d = mem_resp_address;
                    end else begin
                        d_resp_valid_d   = 1'b1;
                        d_resp_data_d    = mem_resp_data;
                        d_resp_address_d = mem_resp_address;
                    end
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q          <= ST_IDLE;
            owner_q          <= OWNER_I;
            op_q             <= OP_READ;
            addr_q           <= '0;
            mem_read_q       <= 1'b0;
            mem_write_q      <= 1'b0;
            mem_address_q    <= '0;
            mem_data_out_q   <= '0;
            i_resp_valid_q   <= 1'b0;
            i_resp_data_q    <= '0;
            i_resp_address_q <= '0;
            d_resp_valid_q   <= 1'b0;
            d_resp_data_q    <= '0;
            d_resp_address_q <= '0;
`ifdef ARB_STARVE_GUARD_EN
            starve_q         <= '0;
`endif
        end else begin
            state_q          <= state_d;
            owner_q          <= owner_d;
            op_q             <= op_d;
            addr_q           <= addr_d;
            mem_read_q       <= mem_read_d;
            mem_write_q      <= mem_write_d;
            mem_address_q    <= mem_address_d;
            mem_data_out_q   <= mem_data_out_d;
            i_resp_valid_q   <= i_resp_valid_d;
            i_resp_data_q    <= i_resp_data_d;
            i_resp_address_q <= i_resp_address_d;
            d_resp_valid_q   <= d_resp_valid_d;
            d_resp_data_q    <= d_resp_data_d;
            d_resp_address_q <= d_resp_address_d;
`ifdef ARB_STARVE_GUARD_EN
            starve_q         <= starve_d;
`endif
        end
    end

    assign mem_read       = mem_read_q;
    assign mem_write      = mem_write_q;
    assign mem_address    = mem_address_q;
    assign mem_data_out   = mem_data_out_q;
    assign i_resp_valid   = i_resp_valid_q;
    assign i_resp_data    = i_resp_data_q;
    assign i_resp_address = i_resp_address_q;
    assign d_resp_valid   = d_resp_valid_q;
    assign d_resp_data    = d_resp_data_q;
    assign d_resp_address = d_resp_address_q;

endmodule
